// File: rtl/ahb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_arbiter_if
//  Purpose  : Request/grant bundle between the AHB-lite masters and the arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface ahb_arbiter_if #(
    parameter int NUM_MASTERS = 3
) ();
    logic [NUM_MASTERS-1:0] hbusreq;
    logic [NUM_MASTERS-1:0] hlock;
    logic                   hready;
    logic [NUM_MASTERS-1:0] hgrant;
    logic [1:0]             hmaster;
    logic [1:0]             hmaster_data;

    // The arbiter owns the grant side of the bundle.
    modport master (
        input  hbusreq, hlock, hready,
        output hgrant, hmaster, hmaster_data
    );

    modport slave (
        output hbusreq, hlock, hready,
        input  hgrant, hmaster, hmaster_data
    );
endinterface
`default_nettype wire

// File: rtl/ahb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_arbiter
//  Purpose  : Round-robin AHB-lite bus arbiter with bounded tenure; optional
//             locked transfers when ARB_LOCK_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 3,
    parameter int MAX_TENURE     = 16,
    parameter int DEFAULT_MASTER = 0
) (
    input wire            hclk,
    input wire            hreset,
    ahb_arbiter_if.master bus
);

    localparam int                     c_TW          = $clog2(MAX_TENURE);
    localparam logic [c_TW-1:0]        c_TENURE_LAST = c_TW'(MAX_TENURE - 1);
    localparam logic [1:0]             c_DEF_IDX     = 2'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] c_ONE         = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
    localparam logic [NUM_MASTERS-1:0] c_DEF_GRANT   = c_ONE << DEFAULT_MASTER;

    typedef enum logic [0:0] {
        S_PARK = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NUM_MASTERS-1:0] r_hgrant;
    logic [NUM_MASTERS-1:0] w_hgrant_nxt;
    logic [c_TW-1:0]        r_tenure;
    logic [c_TW-1:0]        w_tenure_nxt;
    logic [1:0]             r_hmaster;
    logic [1:0]             r_hmaster_data;

    logic [NUM_MASTERS-1:0] w_req;
    logic [1:0]             w_owner;
    logic                   w_any_req;
    logic                   w_owner_req;
    logic                   w_others_req;
    logic [1:0]             w_cand_idx;
    logic                   w_found;
    logic [NUM_MASTERS-1:0] w_next_grant;
    logic [NUM_MASTERS-1:0] w_arb_grant;
    logic [c_TW-1:0]        w_arb_tenure;

    assign w_req        = bus.hbusreq;
    assign w_any_req    = |w_req;
    assign w_owner_req  = |(w_req & r_hgrant);
    assign w_others_req = |(w_req & ~r_hgrant);

`ifdef ARB_LOCK_EN
    logic w_owner_lock;
    assign w_owner_lock = |(bus.hlock & r_hgrant) && w_owner_req;
`else
    logic w_unused_lock;
    assign w_unused_lock = ^bus.hlock;
`endif

    always_comb begin
        w_owner = c_DEF_IDX;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_hgrant[i]) w_owner = 2'(i);
        end
    end

    // Rotating search starting just after the owner; the owner is tried last.
    always_comb begin
        w_cand_idx   = '0;
        w_found      = 1'b0;
        w_next_grant = r_hgrant;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            w_cand_idx = 2'((int'(w_owner) + k) % NUM_MASTERS);
            if (!w_found && |(w_req & (c_ONE << w_cand_idx))) begin
                w_found      = 1'b1;
                w_next_grant = c_ONE << w_cand_idx;
            end
        end
    end

    always_comb begin
        w_arb_grant  = r_hgrant;
        w_arb_tenure = r_tenure;
`ifdef ARB_LOCK_EN
        if (w_owner_lock) begin
            if (w_others_req && r_tenure != c_TENURE_LAST) w_arb_tenure = r_tenure + c_TW'(1);
        end else
`endif
        if (w_owner_req && !w_others_req) begin
            // A lone owner whose tenure has expired starts a fresh tenure.
            if (r_tenure == c_TENURE_LAST) w_arb_tenure = '0;
        end else if (w_owner_req && r_tenure < c_TENURE_LAST) begin
            w_arb_tenure = r_tenure + c_TW'(1);
        end else begin
            w_arb_grant  = w_next_grant;
            w_arb_tenure = '0;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_hgrant_nxt = r_hgrant;
        w_tenure_nxt = r_tenure;
        case (r_state)
            S_PARK: begin
                if (w_any_req) begin
                    w_state_nxt  = S_OWN;
                    w_hgrant_nxt = w_arb_grant;
                    w_tenure_nxt = w_arb_tenure;
                end else begin
                    w_hgrant_nxt = c_DEF_GRANT;
                    w_tenure_nxt = '0;
                end
            end
            S_OWN: begin
                if (!w_any_req) begin
                    w_state_nxt  = S_PARK;
                    w_hgrant_nxt = c_DEF_GRANT;
                    w_tenure_nxt = '0;
                end else begin
                    w_hgrant_nxt = w_arb_grant;
                    w_tenure_nxt = w_arb_tenure;
                end
            end
            default: w_state_nxt = S_PARK;
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state <= S_PARK;
        end else if (bus.hready) begin
            r_state <= w_state_nxt;
        end
    end

    // hmaster follows the grant by one transfer, hmaster_data by two.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_hgrant       <= c_DEF_GRANT;
            r_tenure       <= '0;
            r_hmaster      <= c_DEF_IDX;
            r_hmaster_data <= c_DEF_IDX;
        end else if (bus.hready) begin
            r_hgrant       <= w_hgrant_nxt;
            r_tenure       <= w_tenure_nxt;
            r_hmaster      <= w_owner;
            r_hmaster_data <= r_hmaster;
        end
    end

    assign bus.hgrant       = r_hgrant;
    assign bus.hmaster      = r_hmaster;
    assign bus.hmaster_data = r_hmaster_data;

endmodule
`default_nettype wire
